// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Imported by the arbiter, its interface and the processor top level.
package dmem_arb_pkg;

    localparam int unsigned DMEM_AW = 12;
    localparam int unsigned DMEM_DW = 32;

    typedef enum logic {
        ARB,
        LOCK_D
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_P,
        OWN_D
    } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the dmem syncram port seen by the arbiter.
// The slave modport is the arbiter; the master modport is everything around it.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW = DMEM_AW,
    parameter int unsigned DW = DMEM_DW
) ();

    logic          p_req;
    logic          p_wren;
    logic [AW-1:0] p_address;
    logic [DW-1:0] p_data;
    logic          p_gnt;
    logic          p_rvalid;

    logic          d_req;
    logic          d_wren;
    logic [AW-1:0] d_address;
    logic [DW-1:0] d_data;
    logic          d_lock;
    logic          d_gnt;
    logic          d_rvalid;

    logic [DW-1:0] q_out;
    logic [AW-1:0] address_dmem;
    logic [DW-1:0] data;
    logic          wren;
    logic [DW-1:0] q_dmem;

    modport slave (
        input  p_req, p_wren, p_address, p_data,
        input  d_req, d_wren, d_address, d_data, d_lock,
        input  q_dmem,
        output p_gnt, p_rvalid, d_gnt, d_rvalid,
        output q_out, address_dmem, data, wren
    );

    modport master (
        output p_req, p_wren, p_address, p_data,
        output d_req, d_wren, d_address, d_data, d_lock,
        output q_dmem,
        input  p_gnt, p_rvalid, d_gnt, d_rvalid,
        input  q_out, address_dmem, data, wren
    );

endinterface

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating count of consecutive cycles a pending debug request was refused.
// starve forces the next debug grant once the count reaches MAX_WAIT.
module dmem_arb_wait_ctr #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic starve
);

    localparam logic [3:0] MaxCnt = 4'(MAX_WAIT);

    logic [3:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else if (clr) begin
            cnt_q <= 4'd0;
        end else if (inc && (cnt_q != MaxCnt)) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign starve = (cnt_q == MaxCnt);

endmodule

// File: rtl/dmem_arbiter.sv
// Processor/debug arbiter for the single-port dmem syncram: one access per clock,
// bounded debug wait in shared mode, and an exclusive debug lock for burst loads.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    state_e state_q;
    logic   p_rvalid_q;
    logic   d_rvalid_q;
    logic   p_gnt;
    logic   d_gnt;
    logic   starve;
    owner_e owner;

    dmem_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clock  (clock),
        .reset  (reset),
        .clr    (~bus.d_req | d_gnt),
        .inc    (bus.d_req & ~d_gnt),
        .starve (starve)
    );

    // Grants are combinational from req so the access lands on the same edge.
    always_comb begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        if (state_q == LOCK_D) begin
            d_gnt = bus.d_req;
        end else begin
            d_gnt = bus.d_req & (~bus.p_req | starve);
            p_gnt = bus.p_req & ~d_gnt;
        end
        if (d_gnt) begin
            owner = OWN_D;
        end else if (p_gnt) begin
            owner = OWN_P;
        end else begin
            owner = OWN_NONE;
        end
    end

    always_comb begin
        bus.address_dmem = bus.p_address;
        bus.data         = bus.p_data;
        bus.wren         = 1'b0;
        case (owner)
            OWN_P: begin
                bus.wren = bus.p_wren;
            end
            OWN_D: begin
                bus.address_dmem = bus.d_address;
                bus.data         = bus.d_data;
                bus.wren         = bus.d_wren;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ARB;
            p_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            p_rvalid_q <= bus.p_req & p_gnt & ~bus.p_wren;
            d_rvalid_q <= bus.d_req & d_gnt & ~bus.d_wren;
            case (state_q)
                ARB: begin
                    if (bus.d_req && d_gnt && bus.d_lock) state_q <= LOCK_D;
                end
                LOCK_D: begin
                    if (!bus.d_lock) state_q <= ARB;
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign bus.p_gnt    = p_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.p_rvalid = p_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.q_out    = bus.q_dmem;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a behavioural model
// of the grant, lock and read-return rules, with a syncram model on the memory side.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned MaxWait = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .MAX_WAIT (MaxWait)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Syncram: write at the edge, read data one cycle after the address edge.
    logic [31:0] mem [4096];
    always @(posedge clock) begin
        if (bus.wren) mem[bus.address_dmem] <= bus.data;
        bus.q_dmem <= mem[bus.address_dmem];
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] ref_mem [4096];
    bit          m_lock;
    int unsigned m_refused;
    bit          exp_prv, exp_drv;
    logic [31:0] exp_q;
    bit          last_pg, last_dg;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lock    = 1'b0;
        m_refused = 0;
        exp_prv   = 1'b0;
        exp_drv   = 1'b0;
        last_pg   = 1'b0;
        last_dg   = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.p_req = 1'b0; bus.p_wren = 1'b0; bus.p_address = '0; bus.p_data = '0;
        bus.d_req = 1'b0; bus.d_wren = 1'b0; bus.d_address = '0; bus.d_data = '0;
        bus.d_lock = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied; returns after the next one.
    task automatic cycle();
        bit gp, gd, ew;
        #1;
        if (m_lock) begin
            gd = bus.d_req;
            gp = 1'b0;
        end else begin
            gd = bus.d_req && (!bus.p_req || m_refused >= MaxWait);
            gp = bus.p_req && !gd;
        end
        ew = (gp && bus.p_wren) || (gd && bus.d_wren);
        check_eq("p_gnt", 32'(bus.p_gnt), 32'(gp));
        check_eq("d_gnt", 32'(bus.d_gnt), 32'(gd));
        check_eq("wren", 32'(bus.wren), 32'(ew));
        check_eq("address_dmem", 32'(bus.address_dmem), gd ? 32'(bus.d_address) : 32'(bus.p_address));
        if (ew) check_eq("data", bus.data, gd ? bus.d_data : bus.p_data);
        check_eq("p_rvalid", 32'(bus.p_rvalid), 32'(exp_prv));
        check_eq("d_rvalid", 32'(bus.d_rvalid), 32'(exp_drv));
        if (exp_prv || exp_drv) check_eq("q_out", bus.q_out, exp_q);
        @(posedge clock);
        exp_prv = gp && !bus.p_wren;
        exp_drv = gd && !bus.d_wren;
        if (exp_prv) exp_q = ref_mem[bus.p_address];
        if (exp_drv) exp_q = ref_mem[bus.d_address];
        if (gp && bus.p_wren) ref_mem[bus.p_address] = bus.p_data;
        if (gd && bus.d_wren) ref_mem[bus.d_address] = bus.d_data;
        if (bus.d_req && !gd) m_refused = (m_refused < MaxWait) ? m_refused + 1 : m_refused;
        else m_refused = 0;
        m_lock  = m_lock ? bus.d_lock : (gd && bus.d_lock);
        last_pg = gp;
        last_dg = gd;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clock);
        #1;
        model_reset();
        check_eq("rst_p_rvalid", 32'(bus.p_rvalid), 32'd0);
        check_eq("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        check_eq("rst_gnt", 32'({bus.p_gnt, bus.d_gnt}), 32'd0);
        check_eq("rst_wren", 32'(bus.wren), 32'd0);
        check_eq("rst_state", 32'(dut.state_q), 32'(ARB));
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[12'h010]     = 32'hDEADBEEF;
        ref_mem[12'h010] = 32'hDEADBEEF;
        idle_inputs();
        do_reset();

        // Single processor read.
        bus.p_req = 1'b1; bus.p_address = 12'h010;
        cycle();
        bus.p_req = 1'b0;
        check_eq("t1_p_rvalid", 32'(bus.p_rvalid), 32'd1);
        check_eq("t1_q_out", bus.q_out, 32'hDEADBEEF);
        check_eq("t1_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        cycle();

        // Both held: processor four cycles, debug on the fifth, repeating.
        for (int i = 0; i < 12; i++) begin
            bus.p_req = 1'b1; bus.p_address = 12'(12'h040 + i);
            bus.d_req = 1'b1; bus.d_address = 12'(12'h080 + i);
            cycle();
            check_eq("starve_d_pattern", 32'(last_dg), 32'((i % 5) == 4));
        end
        idle_inputs();
        cycle();

        // Simultaneous writes to one address: processor first, debug second.
        do_reset();
        bus.p_req = 1'b1; bus.p_wren = 1'b1; bus.p_address = 12'h020; bus.p_data = 32'h11111111;
        bus.d_req = 1'b1; bus.d_wren = 1'b1; bus.d_address = 12'h020; bus.d_data = 32'h22222222;
        cycle();
        bus.p_req = 1'b0;
        cycle();
        bus.d_req = 1'b0;
        bus.p_req = 1'b1; bus.p_wren = 1'b0;
        cycle();
        bus.p_req = 1'b0;
        check_eq("wr_readback", bus.q_out, 32'h22222222);
        cycle();

        // Locked debug burst with the processor waiting.
        for (int i = 0; i < 8; i++) begin
            bus.d_req = 1'b1; bus.d_wren = 1'b1; bus.d_lock = 1'b1;
            bus.d_address = 12'(12'h100 + i); bus.d_data = $urandom;
            if (i > 0) begin
                bus.p_req = 1'b1; bus.p_address = 12'h030;
            end
            cycle();
        end
        bus.d_req = 1'b0; bus.d_lock = 1'b0;
        cycle();
        check_eq("unlock_p_wait", 32'(last_pg), 32'd0);
        cycle();
        check_eq("unlock_p_gnt", 32'(last_pg), 32'd1);
        idle_inputs();
        cycle();

        // Reset during lock with a debug read in flight.
        do_reset();
        bus.d_req = 1'b1; bus.d_wren = 1'b1; bus.d_lock = 1'b1; bus.d_address = 12'h200;
        cycle();
        bus.d_wren = 1'b0; bus.d_address = 12'h100;
        cycle();
        reset = 1'b1;
        #1;
        check_eq("midlock_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        check_eq("midlock_state", 32'(dut.state_q), 32'(ARB));
        model_reset();
        idle_inputs();
        bus.p_req = 1'b1; bus.p_address = 12'h105;
        reset = 1'b0;
        cycle();
        check_eq("post_rst_p_gnt", 32'(last_pg), 32'd1);
        bus.p_req = 1'b0;
        cycle();

        // Alternating single-requester reads.
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            if (i % 2 == 0) begin
                bus.p_req = 1'b1; bus.p_address = 12'(12'h100 + i);
            end else begin
                bus.d_req = 1'b1; bus.d_address = 12'(12'h010 + i);
            end
            cycle();
        end
        idle_inputs();
        cycle();

        // Random traffic; requests stay stable until granted.
        for (int i = 0; i < 400; i++) begin
            if (!bus.p_req || last_pg) begin
                bus.p_req     = ($urandom_range(0, 3) != 0);
                bus.p_wren    = 1'($urandom_range(0, 1));
                bus.p_address = 12'($urandom_range(0, 15));
                bus.p_data    = $urandom;
            end
            if (!bus.d_req || last_dg) begin
                bus.d_req     = ($urandom_range(0, 2) != 0);
                bus.d_wren    = 1'($urandom_range(0, 1));
                bus.d_address = 12'($urandom_range(0, 15));
                bus.d_data    = $urandom;
            end
            if ($urandom_range(0, 9) == 0) bus.d_lock = ~bus.d_lock;
            cycle();
        end
        idle_inputs();
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
